// File: rtl/dcache_pkg.sv
// Shared geometry and FSM encoding for the direct-mapped write-back data cache.
package dcache_pkg;

    localparam int unsigned ADDR_W    = 30;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned OFF_W     = 2;
    localparam int unsigned TAG_W     = ADDR_W - IDX_W - OFF_W;
    localparam int unsigned LINE_W    = 32 << OFF_W;
    localparam int unsigned NUM_LINES = 1 << IDX_W;

    typedef enum logic [1:0] {
        S_COMPARE   = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } state_e;

endpackage

// File: rtl/dcache_line_array.sv
// Valid/dirty/tag/data storage for the cache lines: one read port plus a line-fill
// write port and a single-word write port, all addressed by the same index.
module dcache_line_array
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  idx,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_data,
    input  logic              fill_en,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [LINE_W-1:0] fill_data,
    input  logic              word_we,
    input  logic [OFF_W-1:0]  word_off,
    input  logic [31:0]       word_data
);

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [TAG_W-1:0]     tag_d  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];
    logic [LINE_W-1:0]    data_d [NUM_LINES];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d[idx] = 1'b1;
            dirty_d[idx] = 1'b0;
            tag_d[idx]   = fill_tag;
            data_d[idx]  = fill_data;
        end
        if (word_we) begin
            dirty_d[idx] = 1'b1;
            data_d[idx][{word_off, 5'b0} +: 32] = word_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data contents are meaningless until valid is set, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[idx];

endmodule

// File: rtl/dcache_wb_direct.sv
// Direct-mapped, write-back, write-allocate data cache between the core MEM stage
// and a 128-bit block memory. Hits are zero-stall; misses stall until the fill lands.
module dcache_wb_direct
    import dcache_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    proc_read,
    input  logic                    proc_write,
    input  logic [ADDR_W-1:0]       proc_addr,
    input  logic [31:0]             proc_wdata,
    output logic                    proc_stall,
    output logic [31:0]             proc_rdata,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [TAG_W+IDX_W-1:0]  mem_addr,
    output logic [LINE_W-1:0]       mem_wdata,
    input  logic [LINE_W-1:0]       mem_rdata,
    input  logic                    mem_ready
);

    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [OFF_W-1:0]  off;
    logic              req, hit;
    logic              line_valid, line_dirty;
    logic [TAG_W-1:0]  line_tag;
    logic [LINE_W-1:0] line_data;
    logic              fill_en, word_we;
    state_e            state_q, state_d;

    assign tag = proc_addr[ADDR_W-1 -: TAG_W];
    assign idx = proc_addr[OFF_W +: IDX_W];
    assign off = proc_addr[OFF_W-1:0];
    assign req = proc_read | proc_write;
    assign hit = line_valid & (line_tag == tag);

    dcache_line_array u_lines (
        .clk       (clk),
        .rst_n     (rst_n),
        .idx       (idx),
        .rd_valid  (line_valid),
        .rd_dirty  (line_dirty),
        .rd_tag    (line_tag),
        .rd_data   (line_data),
        .fill_en   (fill_en),
        .fill_tag  (tag),
        .fill_data (mem_rdata),
        .word_we   (word_we),
        .word_off  (off),
        .word_data (proc_wdata)
    );

    always_comb begin
        state_d    = state_q;
        proc_stall = 1'b0;
        proc_rdata = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = {tag, idx};
        mem_wdata  = line_data;
        fill_en    = 1'b0;
        word_we    = 1'b0;
        unique case (state_q)
            S_COMPARE: begin
                if (req) begin
                    if (hit) begin
                        // A simultaneous read and write is served as a write.
                        if (proc_write) begin
                            word_we = 1'b1;
                        end else begin
                            proc_rdata = line_data[{off, 5'b0} +: 32];
                        end
                    end else begin
                        proc_stall = 1'b1;
                        state_d    = (line_valid && line_dirty) ? S_WRITEBACK : S_ALLOCATE;
                    end
                end
            end
            S_WRITEBACK: begin
                proc_stall = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {line_tag, idx};
                if (mem_ready) begin
                    state_d = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                if (mem_ready) begin
                    fill_en = 1'b1;
                    state_d = S_COMPARE;
                end
            end
            default: begin
                state_d = S_COMPARE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_COMPARE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule
